// File: rtl/matmul_tile_ctrl_pkg.sv
// Shared definitions for the matmul tile controller slice.
// Holds the controller FSM encoding, the tile geometry constants, the default
// element/address widths and the command tile-count sanitising helper.
package matmul_tile_ctrl_pkg;

   localparam int TILE_DIM      = 4;
   localparam int N_ELEM        = TILE_DIM * TILE_DIM;
   localparam int DW_DEFAULT    = 16;
   localparam int AW_DEFAULT    = 9;
   localparam int K_MAX_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      COLLECT = 3'd2,
      GAP     = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   // A request of zero tiles still runs one tile; oversized requests saturate.
   function automatic logic [3:0] clamp_k_tiles(input logic [3:0] k_req, input int k_max);
      logic [3:0] k_out;
      k_out = k_req;
      if (k_req == 4'd0) begin
         k_out = 4'd1;
      end else if (int'(k_req) > k_max) begin
         k_out = 4'(k_max);
      end
      return k_out;
   endfunction

endpackage

// File: rtl/matmul_tile_ctrl_if.sv
// Bus bundle between the tile controller and its environment.
// Groups three channels:
//   cmd_* : command handshake (valid/ready, A/B base addresses, K-tile count)
//   core_*: control of and results from the 4x4 systolic core
//   res_* : accumulated result stream (valid/ready, data, index, last)
// plus the controller busy flag.
// Modport slave is the controller's view; master is the environment's view.
interface matmul_tile_ctrl_if import matmul_tile_ctrl_pkg::*; #(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_a_base;
   logic [AW-1:0]   cmd_b_base;
   logic [3:0]      cmd_k_tiles;

   logic            core_start;
   logic [AW-1:0]   core_a_loc;
   logic [AW-1:0]   core_b_loc;
   logic            core_done;
   logic [3:0]      core_out_sel;
   logic [2*DW-1:0] core_data;

   logic            res_valid;
   logic            res_ready;
   logic [2*DW-1:0] res_data;
   logic [3:0]      res_idx;
   logic            res_last;

   logic            busy;

   modport slave (
      input  cmd_valid, cmd_a_base, cmd_b_base, cmd_k_tiles,
      input  core_done, core_data, res_ready,
      output cmd_ready, core_start, core_a_loc, core_b_loc, core_out_sel,
      output res_valid, res_data, res_idx, res_last, busy
   );

   modport master (
      output cmd_valid, cmd_a_base, cmd_b_base, cmd_k_tiles,
      output core_done, core_data, res_ready,
      input  cmd_ready, core_start, core_a_loc, core_b_loc, core_out_sel,
      input  res_valid, res_data, res_idx, res_last, busy
   );

endinterface

// File: rtl/matmul_tile_ctrl_acc_bank.sv
// matmul_acc_bank: 16-entry accumulator for one C tile.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears all entries)
//   wr_en            : write strobe
//   wr_add           : 1 = add wr_data to the entry, 0 = overwrite the entry
//   wr_idx, wr_data  : entry index and value for the write port
//   rd_idx, rd_data  : asynchronous read port
module matmul_acc_bank import matmul_tile_ctrl_pkg::*; #(
   parameter int DW = DW_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic            wr_add,
   input  logic [3:0]      wr_idx,
   input  logic [2*DW-1:0] wr_data,
   input  logic [3:0]      rd_idx,
   output logic [2*DW-1:0] rd_data
);

   logic [2*DW-1:0] acc [N_ELEM];

   // Entry update: the first K-tile loads, later tiles add; the sum wraps
   // at the 2*DW result width.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_ELEM; i++) begin
            acc[i] <= '0;
         end
      end else if (wr_en) begin
         acc[wr_idx] <= wr_add ? (acc[wr_idx] + wr_data) : wr_data;
      end
   end

   assign rd_data = acc[rd_idx];

endmodule

// File: rtl/matmul_tile_ctrl.sv
// matmul_tile_ctrl: sequences K tile multiplications on a 4x4 systolic core,
// accumulates the 16 partial C elements and streams the final tile out.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : matmul_tile_ctrl_if.slave (command, core control, result
//                stream and busy flag)
// Flow per command: RUN (wait for core done) -> COLLECT (read 16 results)
// -> GAP (drop start for one cycle to clear the core) -> next tile or DRAIN.
module matmul_tile_ctrl import matmul_tile_ctrl_pkg::*; #(
   parameter int K_MAX = K_MAX_DEFAULT,
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   matmul_tile_ctrl_if.slave   bus
);

   state_t          state;
   state_t          state_next;
   logic [AW-1:0]   a_base;
   logic [AW-1:0]   b_base;
   logic [3:0]      k_tiles;
   logic [3:0]      t;
   logic [4:0]      sel_cnt;
   logic [3:0]      idx;
   logic [AW-1:0]   tile_off;
   logic            acc_wr_en;
   logic            acc_wr_add;
   logic [3:0]      acc_wr_idx;
   logic [2*DW-1:0] acc_rd_data;

   // Each K-tile advances four words in both the A and B buffers.
   assign tile_off = AW'(int'(t) * TILE_DIM);

   // sel_cnt 0..15 selects a result; the core answers one cycle later, so
   // the capture for select n happens while sel_cnt is n+1 (1..16).
   assign acc_wr_en  = (state == COLLECT) && (sel_cnt != 5'd0);
   assign acc_wr_add = (t != 4'd0);
   assign acc_wr_idx = 4'(sel_cnt - 5'd1);

   matmul_acc_bank #(.DW(DW)) u_acc_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (acc_wr_en),
      .wr_add  (acc_wr_add),
      .wr_idx  (acc_wr_idx),
      .wr_data (bus.core_data),
      .rd_idx  (idx),
      .rd_data (acc_rd_data)
   );

   // State register plus the command latches, tile counter, collect counter
   // and drain index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         a_base  <= '0;
         b_base  <= '0;
         k_tiles <= 4'd1;
         t       <= 4'd0;
         sel_cnt <= 5'd0;
         idx     <= 4'd0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.cmd_valid) begin
            a_base  <= bus.cmd_a_base;
            b_base  <= bus.cmd_b_base;
            k_tiles <= clamp_k_tiles(bus.cmd_k_tiles, K_MAX);
            t       <= 4'd0;
         end else if (state == GAP && state_next == RUN) begin
            t <= t + 4'd1;
         end
         sel_cnt <= (state == COLLECT && state_next == COLLECT) ? sel_cnt + 5'd1 : 5'd0;
         if (state == GAP) begin
            idx <= 4'd0;
         end else if (state == DRAIN && bus.res_ready) begin
            idx <= idx + 4'd1;
         end
      end
   end

   // Next-state and output decode; every output defaults to its idle value
   // so that nothing leaks outside the state that owns it.
   always_comb begin
      state_next       = state;
      bus.cmd_ready    = 1'b0;
      bus.core_start   = 1'b0;
      bus.core_a_loc   = '0;
      bus.core_b_loc   = '0;
      bus.core_out_sel = 4'd0;
      bus.res_valid    = 1'b0;
      bus.res_data     = '0;
      bus.res_idx      = 4'd0;
      bus.res_last     = 1'b0;
      bus.busy         = (state != IDLE);
      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            bus.core_start = 1'b1;
            bus.core_a_loc = a_base + tile_off;
            bus.core_b_loc = b_base + tile_off;
            if (bus.core_done) begin
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            bus.core_start   = 1'b1;
            bus.core_a_loc   = a_base + tile_off;
            bus.core_b_loc   = b_base + tile_off;
            bus.core_out_sel = sel_cnt[4] ? 4'd0 : sel_cnt[3:0];
            if (sel_cnt == 5'(N_ELEM)) begin
               state_next = GAP;
            end
         end
         GAP: begin
            state_next = (({1'b0, t} + 5'd1) < {1'b0, k_tiles}) ? RUN : DRAIN;
         end
         DRAIN: begin
            bus.res_valid = 1'b1;
            bus.res_data  = acc_rd_data;
            bus.res_idx   = idx;
            bus.res_last  = (idx == 4'(N_ELEM - 1));
            if (bus.res_ready && idx == 4'(N_ELEM - 1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Self-checking bench for matmul_tile_ctrl.
// A behavioural 4x4 core stub multiplies per-tile A/B matrices held in the
// bench; expected results are plain matrix sums modulo 2^32. The stub also
// logs the tile addresses and the start-low gap seen before each tile.
module tb_matmul_tile_ctrl;
   import matmul_tile_ctrl_pkg::*;

   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int K_MAX = 8;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [15:0] mat_a [K_MAX][4][4];
   logic [15:0] mat_b [K_MAX][4][4];

   logic          start_q;
   int            lat_cnt;
   int            start_count;
   int            tile_sel;
   int            low_len;
   logic [AW-1:0] rec_a [16];
   logic [AW-1:0] rec_b [16];
   int            rec_gap [16];

   matmul_tile_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   matmul_tile_ctrl #(.K_MAX(K_MAX), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One element of A[tile] x B[tile], truncated to the core result width.
   function automatic logic [31:0] prod_elem(input int tile, input logic [3:0] e);
      longint s;
      int r;
      int c;
      s = 0;
      r = int'(e) / 4;
      c = int'(e) % 4;
      if (tile < 0 || tile >= K_MAX) return 32'd0;
      for (int k = 0; k < 4; k++) begin
         s += longint'(mat_a[3'(tile)][2'(r)][2'(k)]) * longint'(mat_b[3'(tile)][2'(k)][2'(c)]);
      end
      return s[31:0];
   endfunction

   // Sum of the first n tile products modulo 2^32.
   function automatic logic [31:0] exp_elem(input int n, input int e);
      longint s;
      s = 0;
      for (int t = 0; t < n; t++) begin
         s += longint'(prod_elem(t, 4'(e)));
      end
      return s[31:0];
   endfunction

   // Behavioural core: done after a random latency while start is held,
   // registered result one cycle after out_sel.
   always @(posedge clk) begin
      if (reset) begin
         start_q       <= 1'b0;
         bus.core_done <= 1'b0;
         bus.core_data <= '0;
         lat_cnt       <= 0;
         start_count   <= 0;
         tile_sel      <= 0;
         low_len       <= 0;
      end else begin
         start_q       <= bus.core_start;
         bus.core_data <= prod_elem(tile_sel, bus.core_out_sel);
         if (!bus.core_start) begin
            bus.core_done <= 1'b0;
            low_len       <= low_len + 1;
         end else if (!start_q) begin
            if (start_count < 16) begin
               rec_a[4'(start_count)]   <= bus.core_a_loc;
               rec_b[4'(start_count)]   <= bus.core_b_loc;
               rec_gap[4'(start_count)] <= low_len;
            end
            tile_sel      <= start_count;
            start_count   <= start_count + 1;
            lat_cnt       <= int'($urandom_range(0, 4));
            low_len       <= 0;
            bus.core_done <= 1'b0;
         end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
         end else begin
            bus.core_done <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // mode 0 random, 1 A=I/B=1..16, 2 all ones, 3 all 0xFFFF
   task automatic fill_tiles(input int mode);
      for (int t = 0; t < K_MAX; t++) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               case (mode)
                  1:       begin mat_a[t][r][c] = (r == c) ? 16'd1 : 16'd0; mat_b[t][r][c] = 16'(r * 4 + c + 1); end
                  2:       begin mat_a[t][r][c] = 16'd1;      mat_b[t][r][c] = 16'd1;      end
                  3:       begin mat_a[t][r][c] = 16'hFFFF;   mat_b[t][r][c] = 16'hFFFF;   end
                  default: begin mat_a[t][r][c] = 16'($urandom); mat_b[t][r][c] = 16'($urandom); end
               endcase
            end
         end
      end
   endtask

   // One full command: accept, wait for the drain, stream out 16 results with
   // the chosen res_ready pattern (0 always, 1 = 1,0,0,1, 2 random), then
   // check addresses, tile count and inter-tile gap.
   task automatic applyStimulus(input string tag, input logic [AW-1:0] a_base, input logic [AW-1:0] b_base,
                                input logic [3:0] k_req, input int ready_mode, input bit poke_cmd);
      int            k_eff;
      int            cyc;
      int            got;
      int            step;
      bit            stalled;
      bit            rdy;
      logic [31:0]   exp_val [16];
      logic [31:0]   hold_data;
      logic [3:0]    hold_idx;
      logic          hold_last;
      logic [AW-1:0] exp_loc;

      k_eff = (k_req == 4'd0) ? 1 : ((int'(k_req) > K_MAX) ? K_MAX : int'(k_req));
      for (int e = 0; e < 16; e++) exp_val[e] = exp_elem(k_eff, e);

      @(negedge clk);
      checkOutput($sformatf("%s.cmd_ready_idle", tag), 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_a_base  = a_base;
      bus.cmd_b_base  = b_base;
      bus.cmd_k_tiles = k_req;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checkOutput($sformatf("%s.busy_run", tag), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("%s.cmd_ready_busy", tag), 32'(bus.cmd_ready), 32'd0);

      cyc = 0;
      while (!bus.res_valid && cyc < 3000) begin
         bus.cmd_valid = poke_cmd && (cyc % 7 == 3);
         bus.cmd_a_base  = AW'($urandom);
         bus.cmd_k_tiles = 4'($urandom_range(1, 8));
         @(negedge clk);
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      checkOutput($sformatf("%s.drain_reached", tag), 32'(bus.res_valid), 32'd1);
      checkOutput($sformatf("%s.out_sel_in_drain", tag), 32'(bus.core_out_sel), 32'd0);
      checkOutput($sformatf("%s.start_in_drain", tag), 32'(bus.core_start), 32'd0);

      got = 0; cyc = 0; step = 0; stalled = 1'b0;
      hold_data = '0; hold_idx = '0; hold_last = 1'b0;
      while (got < 16 && cyc < 400) begin
         case (ready_mode)
            1:       rdy = (step % 4 == 0) || (step % 4 == 3);
            2:       rdy = 1'($urandom);
            default: rdy = 1'b1;
         endcase
         bus.res_ready = rdy;
         if (stalled) begin
            checkOutput($sformatf("%s.hold_data", tag), bus.res_data, hold_data);
            checkOutput($sformatf("%s.hold_idx", tag), 32'(bus.res_idx), 32'(hold_idx));
            checkOutput($sformatf("%s.hold_last", tag), 32'(bus.res_last), 32'(hold_last));
         end
         checkOutput($sformatf("%s.res_valid[%0d]", tag, got), 32'(bus.res_valid), 32'd1);
         checkOutput($sformatf("%s.res_idx[%0d]", tag, got), 32'(bus.res_idx), 32'(got));
         checkOutput($sformatf("%s.res_data[%0d]", tag, got), bus.res_data, exp_val[4'(got)]);
         checkOutput($sformatf("%s.res_last[%0d]", tag, got), 32'(bus.res_last), 32'(got == 15));
         hold_data = bus.res_data;
         hold_idx  = bus.res_idx;
         hold_last = bus.res_last;
         stalled   = !rdy;
         if (rdy) got++;
         step++;
         @(negedge clk);
         cyc++;
      end
      bus.res_ready = 1'b0;
      checkOutput($sformatf("%s.drain_count", tag), 32'(got), 32'd16);
      checkOutput($sformatf("%s.idle_after", tag), 32'(bus.cmd_ready), 32'd1);
      checkOutput($sformatf("%s.valid_after", tag), 32'(bus.res_valid), 32'd0);
      checkOutput($sformatf("%s.busy_after", tag), 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("%s.tiles_run", tag), 32'(start_count), 32'(k_eff));
      for (int t = 0; t < k_eff; t++) begin
         exp_loc = a_base + AW'(4 * t);
         checkOutput($sformatf("%s.a_loc[%0d]", tag, t), 32'(rec_a[t]), 32'(exp_loc));
         exp_loc = b_base + AW'(4 * t);
         checkOutput($sformatf("%s.b_loc[%0d]", tag, t), 32'(rec_b[t]), 32'(exp_loc));
         if (t > 0) checkOutput($sformatf("%s.gap[%0d]", tag, t), 32'(rec_gap[t]), 32'd1);
      end
      // Clear the stub's tile log between commands.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      bad++;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  cyc;
      bit  seen_valid;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_a_base  = '0;
      bus.cmd_b_base  = '0;
      bus.cmd_k_tiles = 4'd0;
      bus.res_ready   = 1'b0;
      fill_tiles(0);
      repeat (3) @(negedge clk);

      checkOutput("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("reset.core_start", 32'(bus.core_start), 32'd0);
      checkOutput("reset.res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("reset.res_last", 32'(bus.res_last), 32'd0);
      checkOutput("reset.busy", 32'(bus.busy), 32'd0);
      checkOutput("reset.a_loc", 32'(bus.core_a_loc), 32'd0);
      checkOutput("reset.b_loc", 32'(bus.core_b_loc), 32'd0);
      checkOutput("reset.out_sel", 32'(bus.core_out_sel), 32'd0);
      checkOutput("reset.res_idx", 32'(bus.res_idx), 32'd0);
      checkOutput("reset.res_data", bus.res_data, 32'd0);
      reset = 1'b0;

      fill_tiles(1);
      applyStimulus("ident", 9'd0, 9'd0, 4'd1, 0, 1'b0);
      fill_tiles(2);
      applyStimulus("ones_k2", 9'd0, 9'd0, 4'd2, 0, 1'b0);
      fill_tiles(0);
      applyStimulus("stall", 9'd17, 9'd300, 4'd3, 1, 1'b1);
      fill_tiles(0);
      applyStimulus("wrap", 9'd510, 9'd509, 4'd2, 2, 1'b0);
      fill_tiles(0);
      applyStimulus("k_zero", 9'($urandom), 9'($urandom), 4'd0, 2, 1'b0);
      fill_tiles(0);
      applyStimulus("k_clamp", 9'($urandom), 9'($urandom), 4'd12, 2, 1'b1);
      fill_tiles(3);
      applyStimulus("overflow", 9'd100, 9'd200, 4'd2, 0, 1'b0);

      // Abort in the middle of the first tile's result collection.
      fill_tiles(0);
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_a_base  = 9'd40;
      bus.cmd_b_base  = 9'd80;
      bus.cmd_k_tiles = 4'd2;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc = 0;
      while (!(bus.core_start && bus.core_out_sel == 4'd7) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("abort.reached_sel7", 32'(bus.core_out_sel), 32'd7);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("abort.core_start", 32'(bus.core_start), 32'd0);
      checkOutput("abort.busy", 32'(bus.busy), 32'd0);
      checkOutput("abort.out_sel", 32'(bus.core_out_sel), 32'd0);
      seen_valid = 1'b0;
      repeat (40) begin
         if (bus.res_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      checkOutput("abort.no_result", 32'(seen_valid), 32'd0);

      fill_tiles(0);
      applyStimulus("recover", 9'($urandom), 9'($urandom), 4'($urandom_range(1, 8)), 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_tile_ctrl.md
MATMUL_TILE_CTRL -- requirements
Module: matmul_tile_ctrl

Interface
REQ-001 Parameter K_MAX, default 8, maximum number of K-tiles per command.
REQ-002 Parameter AW, default 9, BRAM address width.
REQ-003 Parameter DW, default 16, element width; result width is 2*DW.
REQ-004 clk  input  1  clock; all logic on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_a_base  input  AW  A-tile base address (column-major, 4 elements per word).
REQ-009 cmd_b_base  input  AW  B-tile base address (row-major, 4 elements per word).
REQ-010 cmd_k_tiles  input  4  number of K-tiles, 1..K_MAX.
REQ-011 core_start  output  1  drives start_mat_mul of the 4x4 systolic core.
REQ-012 core_a_loc, core_b_loc  output  AW  tile base addresses to the core.
REQ-013 core_done  input  1  core done_mat_mul.
REQ-014 core_out_sel  output  4  result select to the core (C row*4+col).
REQ-015 core_data  input  2*DW  core registered result, valid the cycle after core_out_sel.
REQ-016 res_valid / res_ready  output / input  1  result stream handshake.
REQ-017 res_data  output  2*DW  accumulated C element.
REQ-018 res_idx  output  4  element index 0..15.
REQ-019 res_last  output  1  high with res_idx==15.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states IDLE, RUN, COLLECT, GAP, DRAIN; IDLE on reset.
REQ-022 cmd_ready SHALL be high only in IDLE; on acceptance, latch the bases, latch k_tiles (0 treated as 1, values above K_MAX clamped to K_MAX), clear tile counter t, enter RUN.
REQ-023 RUN: core_start high, core_a_loc = a_base + 4*t, core_b_loc = b_base + 4*t, both modulo 2^AW; stay until core_done is high, then enter COLLECT.
REQ-024 COLLECT: core_start stays high; core_out_sel = 0..15 on 16 consecutive cycles; core_data is captured one cycle later each time, so COLLECT lasts 17 cycles.
REQ-025 Capture rule: acc[i] <= core_data when t==0, else acc[i] + core_data, truncated modulo 2^(2*DW).
REQ-026 GAP: core_start low for exactly 1 cycle, which clears the core; then t+1 < k_tiles -> t++ and RUN, else DRAIN.
REQ-027 DRAIN: res_valid high, res_data = acc[idx], res_idx = idx; idx advances only on res_valid && res_ready; after the transfer with idx==15, go to IDLE.
REQ-028 res_data, res_idx and res_last SHALL hold stable while res_valid && !res_ready.
REQ-029 cmd_valid outside IDLE is ignored (not queued).
REQ-030 core_out_sel SHALL be 0 outside COLLECT.

Reset
REQ-031 Reset SHALL set: state IDLE; cmd_ready 1; core_start, res_valid, res_last, busy 0; core_a_loc, core_b_loc, core_out_sel, res_idx, res_data 0; acc[0..15] 0.
REQ-032 Reset asserted mid-operation SHALL abort within one cycle with the same values; no partial result is emitted.

Structure
REQ-033 Shared package holds the FSM state encoding, the constants TILE_DIM=4 and N_ELEM=16, and the DW/AW defaults.
REQ-034 One sub-module, matmul_acc_bank: 16x(2*DW) accumulator with load/add write port and async read port.

Verification
REQ-035 Reset, then k_tiles=1, a_base=0, b_base=0, A=I, B=1..16 -> core_a_loc=0; res stream yields 1..16 in order, res_last on 16th.
REQ-036 k_tiles=2, bases 0/0, two tiles each contributing all-ones products -> every res_data = 8; core_a_loc sequence 0 then 4; one GAP cycle with core_start=0 between tiles.
REQ-037 res_ready toggling 1,0,0,1 during DRAIN -> no lost or duplicated idx; outputs stable while stalled.
REQ-038 Reset asserted in COLLECT at out_sel=7 -> next cycle IDLE, core_start=0, cmd_ready=1, res_valid never asserted.
REQ-039 a_base=510, k_tiles=2 -> second tile core_a_loc=2 (wrap); cmd_k_tiles=0 -> exactly one tile run.
REQ-040 Accumulation overflow: products summing past 2^32-1 -> res_data equals the sum mod 2^32.
